time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameters: TIMEOUT, 10, idle ticks before an edit is abandoned (range 2..15).
REQ-002 SHALL have ports: clk_1Hz  in  1  tick clock; all state changes on its rising edge.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: mode_btn  in  1  mode/advance button, level, synchronous to clk_1Hz.
REQ-005 SHALL have ports: inc_btn  in  1  increment button, level.
REQ-006 SHALL have ports: dec_btn  in  1  decrement button, level.
REQ-007 SHALL have ports: cur_minutes  in  6  running minutes from the counter (0..59).
REQ-008 SHALL have ports: cur_hours  in  5  running hours from the counter (0..23).
REQ-009 SHALL have ports: set_time_mode  out  1  one-tick load strobe to the counter.
REQ-010 SHALL have ports: set_minutes  out  6  minutes value to load.
REQ-011 SHALL have ports: set_hours  out  5  hours value to load.
REQ-012 SHALL have ports: state  out  2  current FSM state encoding.
REQ-013 SHALL have ports: blink  out  1  display blink enable for the field being edited.

Function
REQ-014 SHALL detect each button's rising edge as btn & ~btn_prev, with btn_prev registered every tick; a level held high produces exactly one edge.
REQ-015 SHALL implement a Moore FSM: RUN=0, EDIT_HR=1, EDIT_MIN=2, COMMIT=3.
REQ-016 RUN: on a mode edge SHALL go to EDIT_HR and load edit_hr<=cur_hours and edit_min<=cur_minutes in that same tick; inc/dec edges are ignored.
REQ-017 EDIT_HR: inc edge SHALL increment edit_hr (23->0 wrap); dec edge SHALL decrement it (0->23 wrap); mode edge SHALL go to EDIT_MIN.
REQ-018 EDIT_MIN: inc edge SHALL increment edit_min (59->0 wrap); dec edge SHALL decrement it (0->59 wrap); mode edge SHALL go to COMMIT.
REQ-019 Simultaneous edges: mode SHALL win, with inc/dec discarded that tick; inc and dec together without mode SHALL leave the value unchanged.
REQ-020 COMMIT SHALL last exactly one tick and then go unconditionally to RUN; all button edges in COMMIT are ignored.
REQ-021 set_time_mode SHALL be 1 only while state==COMMIT; set_hours/set_minutes SHALL always equal edit_hr/edit_min.
REQ-022 An idle counter (4 bit) SHALL clear on entry to any EDIT state and on any button edge, and SHALL increment on every other EDIT tick.
REQ-023 When the idle counter reaches TIMEOUT-1 on a tick with no edge, the FSM SHALL go to RUN on that edge with no COMMIT and no strobe.
REQ-024 blink SHALL toggle every tick in EDIT_HR/EDIT_MIN, start at 1 on entry to an edit state, and be 0 in RUN and COMMIT.
REQ-025 edit registers SHALL hold their value in RUN; out-of-range cur_* loaded at RUN->EDIT_HR SHALL wrap to 0 on the next inc.

Reset
REQ-026 While reset=1, state=RUN, set_time_mode=0, set_minutes=0, set_hours=0, blink=0, idle counter=0, and all btn_prev=0, taking effect immediately regardless of clock.
REQ-027 A button held high through reset release SHALL register one edge on the first tick after release.
REQ-028 A reset during EDIT or COMMIT SHALL abort the edit and issue no strobe.

Verification
REQ-029 cur=12:34, pulse mode, inc x3, mode, dec x1, mode -> set_time_mode high for exactly one tick with hours=15 and minutes=33; then state=RUN.
REQ-030 cur=23:59, mode, inc (hr), mode, inc (min), mode -> set_hours=0 and set_minutes=0 at the strobe.
REQ-031 cur=00:00, mode, dec, mode, dec, mode -> set_hours=23 and set_minutes=59 at the strobe.
REQ-032 Enter EDIT_HR and then stay idle for TIMEOUT=10 ticks -> back in RUN, set_time_mode never asserted, blink=0.
REQ-033 In EDIT_HR, assert mode+inc in the same tick -> state=EDIT_MIN with edit_hr unchanged; inc+dec together -> value unchanged.
REQ-034 Assert reset asynchronously mid-EDIT_MIN -> all outputs 0 and state=RUN immediately; one held-high mode_btn after release -> exactly one RUN->EDIT_HR transition.

Source files
------------

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl
// Purpose  : Button-driven time-setting controller for a 24h clock. A mode
//            press enters hour editing, a second press moves to minute
//            editing, and a third press commits: a one-tick load strobe goes
//            to the running counter. An edit that sits idle for TIMEOUT ticks
//            is dropped with no strobe.
// Ports    : clk_1Hz       - tick clock; all state changes on its rising edge
//            reset         - asynchronous, active-high reset
//            mode_btn      - mode/advance button (level)
//            inc_btn       - increment button (level)
//            dec_btn       - decrement button (level)
//            cur_minutes   - running minutes from the counter (0..59)
//            cur_hours     - running hours from the counter (0..23)
//            set_time_mode - one-tick load strobe, high only in COMMIT
//            set_minutes   - minutes value to load (the edit register)
//            set_hours     - hours value to load (the edit register)
//            state         - FSM state: 0 RUN, 1 EDIT_HR, 2 EDIT_MIN, 3 COMMIT
//            blink         - display blink enable for the field being edited
// Revision : 1.0 - initial release
// ============================================================================
module time_set_ctrl #(
    parameter int TIMEOUT = 10
) (
    input  logic       clk_1Hz,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       dec_btn,
    input  logic [5:0] cur_minutes,
    input  logic [4:0] cur_hours,
    output logic       set_time_mode,
    output logic [5:0] set_minutes,
    output logic [4:0] set_hours,
    output logic [1:0] state,
    output logic       blink
);

    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_EDIT_HR  = 2'd1;
    localparam logic [1:0] c_ST_EDIT_MIN = 2'd2;
    localparam logic [1:0] c_ST_COMMIT   = 2'd3;

    localparam logic [3:0] c_IDLE_LAST = 4'(TIMEOUT - 1);

    logic [1:0] r_state;
    logic [4:0] r_edit_hr;
    logic [5:0] r_edit_min;
    logic [3:0] r_idle;
    logic       r_blink;
    logic       r_mode_prev;
    logic       r_inc_prev;
    logic       r_dec_prev;

    logic       w_mode_edge;
    logic       w_inc_edge;
    logic       w_dec_edge;
    logic       w_any_edge;
    logic       w_step_up;
    logic       w_step_dn;
    logic [1:0] w_state_nxt;
    logic [4:0] w_hr_nxt;
    logic [5:0] w_min_nxt;
    logic [3:0] w_idle_nxt;
    logic       w_blink_nxt;

    assign w_mode_edge = mode_btn & ~r_mode_prev;
    assign w_inc_edge  = inc_btn  & ~r_inc_prev;
    assign w_dec_edge  = dec_btn  & ~r_dec_prev;
    assign w_any_edge  = w_mode_edge | w_inc_edge | w_dec_edge;

    // inc and dec together cancel; mode outranks both (handled in the FSM).
    assign w_step_up = w_inc_edge & ~w_dec_edge;
    assign w_step_dn = w_dec_edge & ~w_inc_edge;

    always_comb begin
        w_state_nxt = r_state;
        w_hr_nxt    = r_edit_hr;
        w_min_nxt   = r_edit_min;
        w_idle_nxt  = 4'd0;
        w_blink_nxt = 1'b0;

        case (r_state)
            c_ST_RUN: begin
                if (w_mode_edge) begin
                    w_state_nxt = c_ST_EDIT_HR;
                    w_hr_nxt    = cur_hours;
                    w_min_nxt   = cur_minutes;
                    w_blink_nxt = 1'b1;
                end
            end

            c_ST_EDIT_HR, c_ST_EDIT_MIN: begin
                if (w_mode_edge) begin
                    w_state_nxt = (r_state == c_ST_EDIT_HR) ? c_ST_EDIT_MIN
                                                            : c_ST_COMMIT;
                    w_blink_nxt = (r_state == c_ST_EDIT_HR);
                end else if (w_any_edge) begin
                    w_blink_nxt = ~r_blink;
                    if (r_state == c_ST_EDIT_HR) begin
                        // ">=" so an out-of-range load wraps to 0 on inc.
                        if (w_step_up)
                            w_hr_nxt = (r_edit_hr >= 5'd23) ? 5'd0 : r_edit_hr + 5'd1;
                        else if (w_step_dn)
                            w_hr_nxt = (r_edit_hr == 5'd0) ? 5'd23 : r_edit_hr - 5'd1;
                    end else begin
                        if (w_step_up)
                            w_min_nxt = (r_edit_min >= 6'd59) ? 6'd0 : r_edit_min + 6'd1;
                        else if (w_step_dn)
                            w_min_nxt = (r_edit_min == 6'd0) ? 6'd59 : r_edit_min - 6'd1;
                    end
                end else if (r_idle == c_IDLE_LAST) begin
                    w_state_nxt = c_ST_RUN;
                end else begin
                    w_idle_nxt  = r_idle + 4'd1;
                    w_blink_nxt = ~r_blink;
                end
            end

            default: begin
                // COMMIT lasts a single tick; button edges are ignored.
                w_state_nxt = c_ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_RUN;
            r_edit_hr   <= 5'd0;
            r_edit_min  <= 6'd0;
            r_idle      <= 4'd0;
            r_blink     <= 1'b0;
            r_mode_prev <= 1'b0;
            r_inc_prev  <= 1'b0;
            r_dec_prev  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_edit_hr   <= w_hr_nxt;
            r_edit_min  <= w_min_nxt;
            r_idle      <= w_idle_nxt;
            r_blink     <= w_blink_nxt;
            r_mode_prev <= mode_btn;
            r_inc_prev  <= inc_btn;
            r_dec_prev  <= dec_btn;
        end
    end

    assign state         = r_state;
    assign set_time_mode = (r_state == c_ST_COMMIT);
    assign set_hours     = r_edit_hr;
    assign set_minutes   = r_edit_min;
    assign blink         = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_set_ctrl
// Purpose  : Directed self-checking bench for time_set_ctrl with hand-computed
//            expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;

    logic       clk_1Hz = 1'b0;
    logic       reset;
    logic       mode_btn;
    logic       inc_btn;
    logic       dec_btn;
    logic [5:0] cur_minutes;
    logic [4:0] cur_hours;
    logic       set_time_mode;
    logic [5:0] set_minutes;
    logic [4:0] set_hours;
    logic [1:0] state;
    logic       blink;

    int n_tests = 0;
    int n_fail  = 0;
    logic stb_seen;

    time_set_ctrl #(.TIMEOUT(10)) u_dut (
        .clk_1Hz      (clk_1Hz),
        .reset        (reset),
        .mode_btn     (mode_btn),
        .inc_btn      (inc_btn),
        .dec_btn      (dec_btn),
        .cur_minutes  (cur_minutes),
        .cur_hours    (cur_hours),
        .set_time_mode(set_time_mode),
        .set_minutes  (set_minutes),
        .set_hours    (set_hours),
        .state        (state),
        .blink        (blink)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one tick; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic drive(input logic m, input logic i, input logic d);
        mode_btn = m;
        inc_btn  = i;
        dec_btn  = d;
        tick();
    endtask

    // Full press: one tick high, one tick released.
    task automatic press(input logic m, input logic i, input logic d);
        drive(m, i, d);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; mode_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
        cur_hours = 5'd12; cur_minutes = 6'd34;
        #23;
        check("rst_state", state, 0);
        check("rst_stb", set_time_mode, 0);
        check("rst_hours", set_hours, 0);
        check("rst_min", set_minutes, 0);
        check("rst_blink", blink, 0);
        reset = 1'b0;
        tick();

        // inc in RUN is ignored
        press(1'b0, 1'b1, 1'b0);
        check("run_inc_ign", state, 0);

        // 12:34 -> 15:33
        drive(1'b1, 1'b0, 1'b0);
        check("enter_hr", state, 1);
        check("enter_hr_val", set_hours, 12);
        check("enter_blink", blink, 1);
        drive(1'b0, 1'b0, 1'b0);
        check("blink_toggle", blink, 0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("hr_inc3", set_hours, 15);
        check("hr_stb_low", set_time_mode, 0);
        press(1'b1, 1'b0, 1'b0);
        check("enter_min", state, 2);
        press(1'b0, 1'b0, 1'b1);
        check("min_dec", set_minutes, 33);
        drive(1'b1, 1'b0, 1'b0);
        check("commit_state", state, 3);
        check("commit_stb", set_time_mode, 1);
        check("commit_hr", set_hours, 15);
        check("commit_min", set_minutes, 33);
        check("commit_blink", blink, 0);
        drive(1'b0, 1'b0, 1'b0);
        check("post_commit_state", state, 0);
        check("post_commit_stb", set_time_mode, 0);

        // 23:59 wrap up -> 00:00
        cur_hours = 5'd23; cur_minutes = 6'd59;
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check("wrapup_stb", set_time_mode, 1);
        check("wrapup_hr", set_hours, 0);
        check("wrapup_min", set_minutes, 0);
        drive(1'b0, 1'b0, 1'b0);

        // 00:00 wrap down -> 23:59
        cur_hours = 5'd0; cur_minutes = 6'd0;
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        check("wrapdn_stb", set_time_mode, 1);
        check("wrapdn_hr", set_hours, 23);
        check("wrapdn_min", set_minutes, 59);
        drive(1'b0, 1'b0, 1'b0);

        // idle timeout: 10 ticks after entry -> RUN, no strobe
        cur_hours = 5'd7; cur_minutes = 6'd8;
        drive(1'b1, 1'b0, 1'b0);
        stb_seen = 1'b0;
        for (int k = 0; k < 9; k++) begin
            drive(1'b0, 1'b0, 1'b0);
            stb_seen |= set_time_mode;
        end
        check("to_still_edit", state, 1);
        drive(1'b0, 1'b0, 1'b0);
        stb_seen |= set_time_mode;
        check("to_run", state, 0);
        check("to_no_stb", stb_seen, 0);
        check("to_blink", blink, 0);

        // simultaneous edges
        cur_hours = 5'd5; cur_minutes = 6'd10;
        press(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        check("modeinc_state", state, 2);
        check("modeinc_hr", set_hours, 5);
        drive(1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        check("incdec_state", state, 2);
        check("incdec_min", set_minutes, 10);

        // async reset mid-EDIT_MIN, then mode held through release
        #2;
        reset = 1'b1;
        mode_btn = 1'b1;
        #1;
        check("arst_state", state, 0);
        check("arst_hr", set_hours, 0);
        check("arst_min", set_minutes, 0);
        check("arst_stb", set_time_mode, 0);
        check("arst_blink", blink, 0);
        #10;
        reset = 1'b0;
        tick();
        check("held_edge", state, 1);
        tick();
        tick();
        tick();
        check("held_single", state, 1);
        drive(1'b0, 1'b0, 1'b0);

        // out-of-range load wraps to 0 on inc
        for (int k = 0; k < 12; k++) drive(1'b0, 1'b0, 1'b0);
        check("back_run", state, 0);
        cur_hours = 5'd31;
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("oor_wrap", set_hours, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
